// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi_sram_slave
//  Brief    : AXI4 slave terminating one socket port onto a single-port
//             synchronous SRAM (1-cycle read latency). Reads and writes are
//             serialised through one FSM; AR/AW ties alternate fairly.
//  Config   : define AXI_SRAM_BURST_EN to serve INCR/FIXED bursts (len 1..255);
//             without it, multi-beat requests are answered with SLVERR and
//             never touch the SRAM.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_sram_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 2,
  parameter int MEM_DEPTH  = 8192
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // write address channel
  input  logic [ID_WIDTH-1:0]           s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]         s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  // write data channel
  input  logic [DATA_WIDTH-1:0]         s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]       s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  // write response channel
  output logic [ID_WIDTH-1:0]           s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  // read address channel
  input  logic [ID_WIDTH-1:0]           s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]         s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  // read data channel
  output logic [ID_WIDTH-1:0]           s_axi_rid,
  output logic [DATA_WIDTH-1:0]         s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  // SRAM port
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [$clog2(MEM_DEPTH)-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]       mem_be_o,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);

  localparam int         c_word_aw = $clog2(MEM_DEPTH);
  localparam logic [1:0] c_fixed   = 2'b00;
  localparam logic [1:0] c_slverr  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DATA = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RD_RESP = 3'd5
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_ready;    // set one edge after reset release
  logic                    r_prio_rd;  // 0: write holds prio, so a tie goes to read
  logic [ID_WIDTH-1:0]     r_id;
  logic [c_word_aw-1:0]    r_addr;
  logic [7:0]              r_len;
  logic [7:0]              r_cnt;
  logic [1:0]              r_burst;
  logic                    r_err;      // unsupported burst: no SRAM access, SLVERR
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic w_grant_wr, w_grant_rd;
  logic w_aw_hs, w_ar_hs, w_w_hs, w_r_hs;
  logic w_aw_err, w_ar_err, w_last_beat;
  logic w_unused;

`ifdef AXI_SRAM_BURST_EN
  assign w_aw_err = 1'b0;
  assign w_ar_err = 1'b0;
`else
  assign w_aw_err = (s_axi_awlen != 8'd0);
  assign w_ar_err = (s_axi_arlen != 8'd0);
`endif

  // Size is ignored (strobes pick lanes), wlast is ignored (beat count ends
  // the burst), and address bits outside the word index alias.
  assign w_unused = ^{s_axi_awsize, s_axi_arsize, s_axi_wlast,
                      s_axi_awaddr, s_axi_araddr};

  // A lone request wins; on a tie the channel not holding prio wins.
  assign w_grant_wr  = s_axi_awvalid && (!s_axi_arvalid || r_prio_rd);
  assign w_grant_rd  = s_axi_arvalid && (!s_axi_awvalid || !r_prio_rd);

  assign w_aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_ar_hs     = s_axi_arvalid && s_axi_arready;
  assign w_w_hs      = s_axi_wvalid  && s_axi_wready;
  assign w_r_hs      = s_axi_rvalid  && s_axi_rready;
  assign w_last_beat = (r_cnt == r_len);

  assign s_axi_bid   = r_id;
  assign s_axi_rid   = r_id;
  assign s_axi_rdata = r_rdata;
  assign mem_addr_o  = r_addr;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and channel/SRAM strobes.
  always_comb begin
    w_state_nxt   = r_state;
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = 2'b00;
    s_axi_rvalid  = 1'b0;
    s_axi_rresp   = 2'b00;
    s_axi_rlast   = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_wdata_o   = '0;
    mem_be_o      = '0;
    case (r_state)
      S_IDLE: begin
        s_axi_awready = r_ready && w_grant_wr;
        s_axi_arready = r_ready && w_grant_rd;
        if (w_aw_hs)      w_state_nxt = S_WR_DATA;
        else if (w_ar_hs) w_state_nxt = S_RD_REQ;
      end
      S_WR_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          mem_req_o   = !r_err;
          mem_we_o    = !r_err;
          mem_wdata_o = r_err ? '0 : s_axi_wdata;
          mem_be_o    = r_err ? '0 : s_axi_wstrb;
          if (w_last_beat) w_state_nxt = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = r_err ? c_slverr : 2'b00;
        if (s_axi_bready) w_state_nxt = S_IDLE;
      end
      S_RD_REQ: begin
        mem_req_o   = !r_err;
        w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_state_nxt = S_RD_RESP;
      end
      S_RD_RESP: begin
        s_axi_rvalid = 1'b1;
        s_axi_rresp  = r_err ? c_slverr : 2'b00;
        s_axi_rlast  = w_last_beat;
        if (s_axi_rready) w_state_nxt = w_last_beat ? S_IDLE : S_RD_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Transaction context, beat counter, arbitration prio and read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ready   <= 1'b0;
      r_prio_rd <= 1'b0;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_burst   <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_ready <= 1'b1;
      if (w_aw_hs) begin
        r_id      <= s_axi_awid;
        r_addr    <= s_axi_awaddr[2 +: c_word_aw];
        r_len     <= s_axi_awlen;
        r_burst   <= s_axi_awburst;
        r_cnt     <= '0;
        r_err     <= w_aw_err;
        r_prio_rd <= !r_prio_rd;
      end else if (w_ar_hs) begin
        r_id      <= s_axi_arid;
        r_addr    <= s_axi_araddr[2 +: c_word_aw];
        r_len     <= s_axi_arlen;
        r_burst   <= s_axi_arburst;
        r_cnt     <= '0;
        r_err     <= w_ar_err;
        r_prio_rd <= !r_prio_rd;
      end
      // WRAP is served as INCR; word index wraps naturally modulo MEM_DEPTH.
      if ((w_w_hs || w_r_hs) && !w_last_beat) begin
        r_cnt <= r_cnt + 8'd1;
        if (r_burst != c_fixed) r_addr <= r_addr + 1'b1;
      end
      if (r_state == S_RD_WAIT) r_rdata <= r_err ? '0 : mem_rdata_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_sram_slave
//  Brief    : Self-checking bench for axi_sram_slave with an SRAM model and a
//             word-array reference memory. Honours AXI_SRAM_BURST_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;
  localparam int DEPTH = 8192;
  localparam int WA    = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  s_axi_awid = '0;   logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;  logic [2:0]  s_axi_awsize = 3'd2;
  logic [1:0]  s_axi_awburst = 2'b01; logic s_axi_awvalid = 1'b0; logic s_axi_awready;
  logic [31:0] s_axi_wdata = '0;  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0; logic s_axi_wvalid = 1'b0; logic s_axi_wready;
  logic [1:0]  s_axi_bid, s_axi_bresp; logic s_axi_bvalid; logic s_axi_bready = 1'b0;
  logic [1:0]  s_axi_arid = '0;   logic [31:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;  logic [2:0]  s_axi_arsize = 3'd2;
  logic [1:0]  s_axi_arburst = 2'b01; logic s_axi_arvalid = 1'b0; logic s_axi_arready;
  logic [1:0]  s_axi_rid, s_axi_rresp; logic [31:0] s_axi_rdata;
  logic        s_axi_rlast, s_axi_rvalid; logic s_axi_rready = 1'b0;
  logic        mem_req_o, mem_we_o;
  logic [WA-1:0] mem_addr_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  axi_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(2), .MEM_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  logic [96:0] all_outs;
  assign all_outs = {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_bid,
                     s_axi_bresp, s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp,
                     s_axi_rlast, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o};

  // SRAM device model: byte-enabled write, one-cycle read latency.
  logic [31:0] sram [DEPTH];
  logic [31:0] sram_q = '0;
  assign mem_rdata_i = sram_q;
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        sram_q <= sram[mem_addr_o];
      end
    end
  end

  // Record of every SRAM access.
  typedef struct packed { logic we; logic [WA-1:0] addr; logic [31:0] data; logic [3:0] be; } acc_t;
  acc_t mon_q[$];
  always @(negedge clk)
    if (rst_n && mem_req_o) mon_q.push_back(acc_t'{mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o});

  // Reference memory and stimulus / observation queues.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  logic [31:0] got_d[$];
  logic [1:0]  got_resp[$];
  logic [1:0]  got_id[$];
  logic        got_last[$];
  int          got_gap[$];
  int          w_lat;
  int total = 0;
  int bad = 0;

  function automatic bit burst_ok(input logic [7:0] len);
`ifdef AXI_SRAM_BURST_EN
    return (len == 8'd0) || 1'b1;
`else
    return (len == 8'd0);
`endif
  endfunction

  function automatic int beat_addr(input logic [31:0] a, input int i, input logic [1:0] burst);
    int w;
    w = int'(a[14:2]);
    return (w + ((burst == 2'b00) ? 0 : i)) % DEPTH;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
    int w;
    if (!burst_ok(len)) return;
    for (int i = 0; i <= int'(len); i++) begin
      w = beat_addr(a, i, burst);
      for (int b = 0; b < 4; b++)
        if (ws_q[i][b]) ref_mem[w][8*b +: 8] = wd_q[i][8*b +: 8];
    end
  endtask

  // ---------------- bus drivers (start and end at posedge+1) ----------------
  task automatic send_aw(input logic [1:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] burst);
    s_axi_awid = id; s_axi_awaddr = a; s_axi_awlen = len; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (s_axi_awready) break;
      if (i == 100) begin total++; bad++; $display("FAIL aw_timeout awready=0 want=1"); break; end
    end
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [1:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] burst);
    s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = len; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (s_axi_arready) break;
      if (i == 100) begin total++; bad++; $display("FAIL ar_timeout arready=0 want=1"); break; end
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic send_w(input int n);
    int cnt;
    for (int b = 0; b < n; b++) begin
      s_axi_wdata = wd_q[b]; s_axi_wstrb = ws_q[b]; s_axi_wlast = (b == n-1); s_axi_wvalid = 1'b1;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!s_axi_wready && cnt < 100);
      if (!s_axi_wready) begin total++; bad++; $display("FAIL w_timeout wready=0 want=1"); break; end
      if (b == 0) w_lat = cnt;
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
  endtask

  task automatic recv_b(output logic [1:0] id, output logic [1:0] resp, output int lat);
    int cnt;
    cnt = 0; id = '0; resp = '0;
    s_axi_bready = 1'b1;
    do begin @(negedge clk); cnt++; end while (!s_axi_bvalid && cnt < 100);
    if (!s_axi_bvalid) begin total++; bad++; $display("FAIL b_timeout bvalid=0 want=1"); end
    id = s_axi_bid; resp = s_axi_bresp; lat = cnt;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic recv_r(input int n);
    int cnt;
    got_d.delete(); got_resp.delete(); got_id.delete(); got_last.delete(); got_gap.delete();
    s_axi_rready = 1'b1;
    for (int b = 0; b < n; b++) begin
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!s_axi_rvalid && cnt < 100);
      if (!s_axi_rvalid) begin total++; bad++; $display("FAIL r_timeout rvalid=0 want=1"); break; end
      got_d.push_back(s_axi_rdata); got_resp.push_back(s_axi_rresp);
      got_id.push_back(s_axi_rid); got_last.push_back(s_axi_rlast); got_gap.push_back(cnt);
      @(posedge clk); #1;
    end
    s_axi_rready = 1'b0;
  endtask

  task automatic write_txn(input logic [1:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] burst, output logic [1:0] bid, output logic [1:0] bresp,
                           output int blat);
    send_aw(id, a, len, burst);
    send_w(int'(len) + 1);
    recv_b(bid, bresp, blat);
    ref_write(a, len, burst);
  endtask

  // ------------------------------- tests -----------------------------------
  task automatic test_reset();
    s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_outs); end
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1; s_axi_awvalid = 1'b1; #1;
    total++;
    if (s_axi_awready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b want=0", s_axi_awready); end
    #1 s_axi_awvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_arbitration();
    bit prio_is_wr; bit exp_aw; logic [1:0] bid, bresp; int blat;
    prio_is_wr = 1'b1;
    s_axi_awid = 2'd1; s_axi_awaddr = 32'h80; s_axi_awlen = 8'd0; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    s_axi_arid = 2'd2; s_axi_araddr = 32'h40; s_axi_arlen = 8'd0; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    @(negedge clk);
    exp_aw = !prio_is_wr;
    total++;
    if ({s_axi_awready, s_axi_arready} !== {exp_aw, !exp_aw}) begin
      bad++; $display("FAIL tie1_grant got aw/ar=%b%b want=%b%b", s_axi_awready, s_axi_arready, exp_aw, !exp_aw);
    end
    prio_is_wr = !prio_is_wr;
    @(posedge clk); #1; s_axi_arvalid = 1'b0;
    recv_r(1);
    total++;
    if (got_d.size() != 1 || got_d[0] !== ref_mem[16] || got_id[0] !== 2'd2) begin
      bad++; $display("FAIL tie1_read got=%h want=%h", (got_d.size() > 0) ? got_d[0] : 32'hx, ref_mem[16]);
    end
    s_axi_arid = 2'd3; s_axi_araddr = 32'h44; s_axi_arvalid = 1'b1;
    @(negedge clk);
    exp_aw = !prio_is_wr;
    total++;
    if ({s_axi_awready, s_axi_arready} !== {exp_aw, !exp_aw}) begin
      bad++; $display("FAIL tie2_grant got aw/ar=%b%b want=%b%b", s_axi_awready, s_axi_arready, exp_aw, !exp_aw);
    end
    @(posedge clk); #1; s_axi_awvalid = 1'b0;
    @(negedge clk);
    total++;
    if ({s_axi_arready, s_axi_wready} !== 2'b01) begin
      bad++; $display("FAIL busy_arready got ar/w=%b%b want=01", s_axi_arready, s_axi_wready);
    end
    @(posedge clk); #1;
    wd_q = '{32'hCAFEF00D}; ws_q = '{4'hF};
    send_w(1);
    recv_b(bid, bresp, blat);
    ref_write(32'h80, 8'd0, 2'b01);
    total++;
    if ({bid, bresp} !== {2'd1, 2'b00}) begin bad++; $display("FAIL tie2_bresp got=%h want=%h", {bid, bresp}, 4'h4); end
    send_ar(2'd3, 32'h44, 8'd0, 2'b01);
    recv_r(1);
    total++;
    if (got_d.size() != 1 || got_d[0] !== ref_mem[17] || got_id[0] !== 2'd3) begin
      bad++; $display("FAIL pending_read got=%h want=%h", (got_d.size() > 0) ? got_d[0] : 32'hx, ref_mem[17]);
    end
  endtask

  task automatic test_single_rw();
    logic [1:0] bid, bresp; int blat;
    mon_q.delete();
    wd_q = '{32'hDEADBEEF}; ws_q = '{4'hF};
    write_txn(2'd2, 32'h40, 8'd0, 2'b01, bid, bresp, blat);
    total++;
    if ({bid, bresp} !== {2'd2, 2'b00}) begin bad++; $display("FAIL single_b got id/resp=%h want=%h", {bid, bresp}, 4'h8); end
    total++;
    if (w_lat != 1 || blat != 1) begin bad++; $display("FAIL write_latency got w=%0d b=%0d want 1/1", w_lat, blat); end
    total++;
    if (mon_q.size() != 1 || mon_q[0] !== acc_t'{1'b1, 13'h10, 32'hDEADBEEF, 4'hF}) begin
      bad++; $display("FAIL single_mem_write got n=%0d want 1 access at 0x10", mon_q.size());
    end
    mon_q.delete();
    send_ar(2'd1, 32'h40, 8'd0, 2'b01);
    recv_r(1);
    total++;
    if (got_d.size() != 1 || {got_d[0], got_id[0], got_resp[0], got_last[0]} !== {32'hDEADBEEF, 2'd1, 2'b00, 1'b1}) begin
      bad++; $display("FAIL single_read got=%h want=deadbeef", (got_d.size() > 0) ? got_d[0] : 32'hx);
    end
    total++;
    if (got_gap.size() != 1 || got_gap[0] != 3) begin bad++; $display("FAIL read_latency got=%0d want=3", (got_gap.size() > 0) ? got_gap[0] : -1); end
    total++;
    if (mon_q.size() != 1 || mon_q[0].we !== 1'b0 || mon_q[0].addr !== 13'h10) begin
      bad++; $display("FAIL single_mem_read got n=%0d want 1 read at 0x10", mon_q.size());
    end
  endtask

  task automatic test_strobe();
    logic [1:0] bid, bresp; int blat;
    wd_q = '{32'h11223344}; ws_q = '{4'b0101};
    write_txn(2'd0, 32'h40, 8'd0, 2'b01, bid, bresp, blat);
    send_ar(2'd0, 32'h40, 8'd0, 2'b01);
    recv_r(1);
    total++;
    if (got_d.size() != 1 || got_d[0] !== 32'hDE22BE44 || got_d[0] !== ref_mem[16]) begin
      bad++; $display("FAIL strobe_merge got=%h want=de22be44", (got_d.size() > 0) ? got_d[0] : 32'hx);
    end
  endtask

  task automatic test_random();
    logic [31:0] a; logic [1:0] id, bid, bresp; int blat, w;
    for (int it = 0; it < 24; it++) begin
      a = $urandom();
      w = 48 + int'($urandom_range(0, 7));
      a[14:2] = w[12:0];
      id = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        wd_q = '{$urandom()}; ws_q = '{4'($urandom_range(0, 15))};
        write_txn(id, a, 8'd0, 2'($urandom_range(0, 2)), bid, bresp, blat);
        total++;
        if ({bid, bresp} !== {id, 2'b00}) begin bad++; $display("FAIL rand_b it=%0d got=%h want=%h", it, {bid, bresp}, {id, 2'b00}); end
      end else begin
        send_ar(id, a, 8'd0, 2'b01);
        recv_r(1);
        total++;
        if (got_d.size() != 1 || got_d[0] !== ref_mem[w] || got_id[0] !== id || got_last[0] !== 1'b1) begin
          bad++; $display("FAIL rand_r it=%0d got=%h want=%h", it, (got_d.size() > 0) ? got_d[0] : 32'hx, ref_mem[w]);
        end
      end
    end
  endtask

  task automatic test_burst();
    logic [1:0] bid, bresp; int blat; bit ok;
`ifdef AXI_SRAM_BURST_EN
    mon_q.delete();
    send_ar(2'd1, 32'((DEPTH-1)*4), 8'd3, 2'b01);
    recv_r(4);
    ok = (got_d.size() == 4) && (mon_q.size() == 4);
    for (int i = 0; ok && i < 4; i++) begin
      w_lat = beat_addr(32'((DEPTH-1)*4), i, 2'b01);
      if (got_d[i] !== ref_mem[w_lat] || got_last[i] !== (i == 3) || got_resp[i] !== 2'b00 ||
          int'(mon_q[i].addr) != w_lat || got_gap[i] != 3) ok = 0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL incr_wrap_read got beats=%0d acc=%0d want 4/4", got_d.size(), mon_q.size()); end
    mon_q.delete();
    wd_q = '{32'hA5A5A5A5, 32'h5A5A5A5A}; ws_q = '{4'hF, 4'hF};
    write_txn(2'd2, 32'h100, 8'd1, 2'b00, bid, bresp, blat);
    total++;
    if (mon_q.size() != 2 || mon_q[0].addr !== 13'h40 || mon_q[1].addr !== 13'h40 || bresp !== 2'b00) begin
      bad++; $display("FAIL fixed_write got acc=%0d resp=%b want 2 at 0x40 resp 00", mon_q.size(), bresp);
    end
    send_ar(2'd2, 32'h100, 8'd0, 2'b01);
    recv_r(1);
    total++;
    if (got_d.size() != 1 || got_d[0] !== ref_mem[64]) begin
      bad++; $display("FAIL fixed_readback got=%h want=%h", (got_d.size() > 0) ? got_d[0] : 32'hx, ref_mem[64]);
    end
`else
    mon_q.delete();
    wd_q = '{32'h01020304, 32'h05060708}; ws_q = '{4'hF, 4'hF};
    write_txn(2'd3, 32'h200, 8'd1, 2'b01, bid, bresp, blat);
    total++;
    if (mon_q.size() != 0 || {bid, bresp} !== {2'd3, 2'b10}) begin
      bad++; $display("FAIL err_write got acc=%0d id/resp=%h want 0 and %h", mon_q.size(), {bid, bresp}, 4'he);
    end
    send_ar(2'd1, 32'h40, 8'd2, 2'b01);
    recv_r(3);
    ok = (got_d.size() == 3) && (mon_q.size() == 0);
    for (int i = 0; ok && i < 3; i++)
      if (got_d[i] !== 32'h0 || got_resp[i] !== 2'b10 || got_last[i] !== (i == 2) ||
          got_id[i] !== 2'd1 || got_gap[i] != 3) ok = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL err_read got beats=%0d acc=%0d want 3/0", got_d.size(), mon_q.size()); end
`endif
  endtask

  task automatic test_stall_reset();
    int cnt;
    send_ar(2'd3, 32'h40, 8'd0, 2'b01);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!s_axi_rvalid && cnt < 100);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if ({s_axi_rvalid, s_axi_rdata, s_axi_rid} !== {1'b1, ref_mem[16], 2'd3}) begin
        bad++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", i, s_axi_rdata, ref_mem[16]);
      end
    end
    @(posedge clk); #1; rst_n = 1'b0; #1;
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL midburst_reset got=%h want=0", all_outs); end
    @(posedge clk); #1; rst_n = 1'b1;
    send_ar(2'd2, 32'h44, 8'd0, 2'b01);
    recv_r(1);
    total++;
    if (got_d.size() != 1 || got_d[0] !== ref_mem[17] || got_id[0] !== 2'd2 || got_gap[0] != 3) begin
      bad++; $display("FAIL post_reset_read got=%h want=%h", (got_d.size() > 0) ? got_d[0] : 32'hx, ref_mem[17]);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram[i] = $urandom();
      ref_mem[i] = sram[i];
    end
    test_reset();
    test_arbitration();
    test_single_rw();
    test_strobe();
    test_random();
    test_burst();
    test_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI4 slave that terminates one master port of the RVM socket (instruction or data side, after the crossbar) onto a single-port synchronous SRAM with one-cycle read latency. It serialises reads and writes through one FSM and arbitrates simultaneous AR/AW requests fairly. It returns ID-tagged responses, with optional INCR/FIXED burst support.

## Interface
- DATA_WIDTH, 32, AXI and SRAM data width; only 32 is supported.
- ADDR_WIDTH, 32, AXI byte-address width.
- ID_WIDTH, 2, AXI ID width.
- MEM_DEPTH, 8192, SRAM depth in words; power of two.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- s_axi_aw{id,addr,len,size,burst,valid} / s_axi_awready  in/out  AXI4 widths  write address channel.
- s_axi_w{data,strb,last,valid} / s_axi_wready  in/out  32/4/1/1  write data channel.
- s_axi_b{id,resp,valid} / s_axi_bready  out/in  ID_WIDTH/2/1  write response channel.
- s_axi_ar{id,addr,len,size,burst,valid} / s_axi_arready  in/out  AXI4 widths  read address channel.
- s_axi_r{id,data,resp,last,valid} / s_axi_rready  out/in  ID_WIDTH/32/2/1/1  read data channel.
- mem_req_o  out  1  SRAM access strobe.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  log2(MEM_DEPTH)  SRAM word address.
- mem_wdata_o  out  32  SRAM write data.
- mem_be_o  out  4  SRAM byte enables.
- mem_rdata_i  in  32  SRAM read data, valid the cycle after a read request.

## Operation
- FSM states: IDLE, WR_DATA, WR_RESP, RD_REQ, RD_WAIT, RD_RESP.
- IDLE:
  - awready and arready are high only when the registered ready_q flag is set and the channel is granted.
  - When only one channel is valid, that channel is granted.
  - When both are valid, the channel other than prio_q is granted; prio_q toggles on every grant and resets to "write", so reads win the first tie.
- On a grant, the block latches id, word address (addr[2+:log2(MEM_DEPTH)]), len and burst, and clears the beat counter.
- Upper address bits alias.
- size is ignored; strobes select lanes.
- Write path:
  - In WR_DATA, wready=1.
  - Each W handshake drives mem_req_o=1, mem_we_o=1, mem_wdata_o=wdata, mem_be_o=wstrb in the same cycle.
  - After beat len+1, the FSM goes to WR_RESP. The beat count alone ends the burst; wlast is ignored.
  - In WR_RESP, bvalid=1 with bid and bresp held until bready, then the FSM returns to IDLE.
- Read path:
  - In RD_REQ, mem_req_o=1 and mem_we_o=0.
  - In RD_WAIT, mem_rdata_i is captured into the rdata register.
  - In RD_RESP, rvalid=1, rresp=OKAY, and rlast=1 when the beat counter equals len; all are held until rready.
  - After each R handshake, the FSM goes to RD_REQ if more beats remain, otherwise to IDLE.
- Address update per beat: INCR (and WRAP, which is treated as INCR) adds 1 word, wrapping modulo MEM_DEPTH. FIXED keeps the address.
- Reset mid-burst: the FSM returns to IDLE, the burst is abandoned, and no response is issued.

## Timing
- While rst_ni is low, every output is 0, ready_q is 0, and prio_q selects write. ready_q sets on the first clock edge after reset release.
- Read latency: AR handshake in cycle T, mem_req_o in T+1, capture in T+2, rvalid in T+3. Each further beat is RD_REQ, RD_WAIT, RD_RESP, so the throughput is 1 beat per 3 cycles with rready held high.
- Write latency: AW handshake in cycle T, wready from T+1. With wvalid held high, a burst of len+1 beats completes in T+1..T+1+len, and bvalid is asserted the cycle after the last beat.
- awready/arready are never high outside IDLE. Requests arriving during a transaction wait.

## Configuration
- AXI_SRAM_BURST_EN defined: len 0..255 is served as described above.
- AXI_SRAM_BURST_EN undefined, any request with len≠0:
  - Write: all len+1 W beats are accepted, mem_req_o stays 0, and bresp=SLVERR (2'b10).
  - Read: the SRAM is not accessed and len+1 beats are returned with rdata=0 and rresp=SLVERR. Beat pacing is unchanged.
- Single-beat requests behave identically in both configurations.

## Test plan
- Single write of 0xDEADBEEF to 0x40, strb 4'hF, then read of 0x40 -> mem_addr_o=0x10; bresp=0, bid echoed; rdata=0xDEADBEEF, rlast=1, rvalid exactly 3 cycles after the AR handshake.
- Write to 0x40 with strb 4'b0101 and data 0x11223344 over 0xDEADBEEF -> a readback of 0xDE22BE44.
- AW and AR valid in the same cycle straight after reset -> read granted first, write granted next; a second tie -> write first.
- With AXI_SRAM_BURST_EN: INCR read with len=3 at the top word (MEM_DEPTH-1) -> addresses MEM_DEPTH-1, 0, 1, 2; rlast only on the 4th beat. FIXED write with len=1 -> both beats hit one address.
- Without AXI_SRAM_BURST_EN: write with len=1 -> no mem_req_o, bresp=2'b10. Read with len=2 -> 3 beats, rresp=2'b10, rdata=0.
- Hold rready low for 5 cycles mid-burst, then assert rst_ni=0 -> rdata/rid stable while stalled; after reset all outputs are 0 and the first AR is accepted normally.
